// File: rtl/sha_header_driver.sv
// Purpose: drives an external SHA-256 core over an 80-byte block header, stepping the nonce until the digest is <= target.
// Latency: per nonce, 1 start cycle, the core's two block times, then 1 check cycle; with DOUBLE_HASH_EN add 1 gap cycle, 1 start cycle and one more block time.
// Backpressure: go is only accepted in IDLE (busy=0); the core paces the search through core_blk_done.
//
// Build option: define DOUBLE_HASH_EN for SHA256d (the first digest is hashed again).
// Without it, the first digest is the final digest.
//
// Ports:
//   CLK, nreset                    clock (rising edge), asynchronous active-low reset
//   go, header, target, nonce_count  search request and its parameters (latched on go)
//   core_start, core_msg, core_blk_type  block stream to the SHA core
//   core_hash, core_blk_done       per-block digest from the SHA core
//   busy, done, found, nonce_out, digest  search status and result
module sha_header_driver (
    input  logic         CLK,
    input  logic         nreset,
    input  logic         go,
    input  logic [639:0] header,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_count,
    output logic         core_start,
    output logic [511:0] core_msg,
    output logic [1:0]   core_blk_type,
    input  logic [255:0] core_hash,
    input  logic         core_blk_done,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [255:0] digest
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] H1_START = 3'd1;
    localparam logic [2:0] H1_B1    = 3'd2;
    localparam logic [2:0] H1_B2    = 3'd3;
`ifdef DOUBLE_HASH_EN
    localparam logic [2:0] H2_START = 3'd4;
    localparam logic [2:0] H2_B     = 3'd5;
`endif
    localparam logic [2:0] CHECK    = 3'd6;
    localparam logic [2:0] FINISH   = 3'd7;

    localparam logic [1:0] BLK_HASH   = 2'd0;
    localparam logic [1:0] BLK_HEADER = 2'd2;

    logic [2:0]   state;
    // hdr_q[i] holds header[i+32]; the nonce field lives in nonce_q instead.
    logic [607:0] hdr_q;
    logic [255:0] target_q;
    logic [31:0]  count_q;
    logic [31:0]  nonce_q;
    logic [31:0]  tries_q;
    logic         pass_q;
`ifdef DOUBLE_HASH_EN
    logic [255:0] digest1_q;
    // Holds H2_START one extra cycle so the core is back in its idle state before the next start.
    logic         gap_q;
`endif

    logic [511:0] blk1;
    logic [511:0] blk2;

    // Block 1 is header[639:128]; block 2 is the header tail, the live nonce and SHA padding for 640 bits.
    assign blk1 = hdr_q[607:96];
    assign blk2 = {hdr_q[95:0], nonce_q, 1'b1, 319'b0, 64'd640};

    always_comb begin
        busy          = (state != IDLE);
        done          = (state == FINISH);
        core_start    = (state == H1_START);
        core_msg      = '0;
        core_blk_type = 2'd0;
        case (state)
            H1_START, H1_B1: begin
                core_msg      = blk1;
                core_blk_type = BLK_HEADER;
            end
            H1_B2: begin
                core_msg      = blk2;
                core_blk_type = BLK_HEADER;
            end
`ifdef DOUBLE_HASH_EN
            H2_START, H2_B: begin
                // Second pass hashes the 256-bit first digest, padded as a single block.
                core_msg      = {digest1_q, 1'b1, 191'b0, 64'd256};
                core_blk_type = BLK_HASH;
                if (state == H2_START && !gap_q) begin
                    core_start = 1'b1;
                end
            end
`endif
            default: begin
                core_msg      = '0;
                core_blk_type = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            hdr_q     <= '0;
            target_q  <= '0;
            count_q   <= '0;
            nonce_q   <= '0;
            tries_q   <= '0;
            pass_q    <= 1'b0;
            found     <= 1'b0;
            nonce_out <= '0;
            digest    <= '0;
`ifdef DOUBLE_HASH_EN
            digest1_q <= '0;
            gap_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        hdr_q    <= header[639:32];
                        target_q <= target;
                        count_q  <= (nonce_count == 32'd0) ? 32'd1 : nonce_count;
                        nonce_q  <= header[31:0];
                        tries_q  <= 32'd1;
                        found    <= 1'b0;
                        state    <= H1_START;
                    end
                end
                H1_START: state <= H1_B1;
                H1_B1: begin
                    if (core_blk_done) begin
                        state <= H1_B2;
                    end
                end
                H1_B2: begin
                    if (core_blk_done) begin
`ifdef DOUBLE_HASH_EN
                        digest1_q <= core_hash;
                        gap_q     <= 1'b1;
                        state     <= H2_START;
`else
                        // Compare is taken from the core output on the capture edge.
                        digest    <= core_hash;
                        pass_q    <= (core_hash <= target_q);
                        state     <= CHECK;
`endif
                    end
                end
`ifdef DOUBLE_HASH_EN
                H2_START: begin
                    if (gap_q) begin
                        gap_q <= 1'b0;
                    end else begin
                        state <= H2_B;
                    end
                end
                H2_B: begin
                    if (core_blk_done) begin
                        digest <= core_hash;
                        pass_q <= (core_hash <= target_q);
                        state  <= CHECK;
                    end
                end
`endif
                CHECK: begin
                    if (pass_q) begin
                        found     <= 1'b1;
                        nonce_out <= nonce_q;
                        state     <= FINISH;
                    end else if (tries_q == count_q) begin
                        found     <= 1'b0;
                        nonce_out <= nonce_q;
                        state     <= FINISH;
                    end else begin
                        nonce_q <= nonce_q + 32'd1;
                        tries_q <= tries_q + 32'd1;
                        state   <= H1_START;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_header_driver.sv
module tb_sha_header_driver;

    logic         CLK = 1'b0;
    logic         nreset;
    logic         go;
    logic [639:0] header;
    logic [255:0] target;
    logic [31:0]  nonce_count;
    logic         core_start;
    logic [511:0] core_msg;
    logic [1:0]   core_blk_type;
    logic [255:0] core_hash = '0;
    logic         core_blk_done;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  nonce_out;
    logic [255:0] digest;

    logic m_done   = 1'b0;
    logic inj_done = 1'b0;
    assign core_blk_done = m_done | inj_done;

    always #5 CLK = ~CLK;

    sha_header_driver dut (
        .CLK           (CLK),
        .nreset        (nreset),
        .go            (go),
        .header        (header),
        .target        (target),
        .nonce_count   (nonce_count),
        .core_start    (core_start),
        .core_msg      (core_msg),
        .core_blk_type (core_blk_type),
        .core_hash     (core_hash),
        .core_blk_done (core_blk_done),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .nonce_out     (nonce_out),
        .digest        (digest)
    );

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic         fnd;
        logic [31:0]  nonce;
        logic [255:0] dig;
    } res_t;

    res_t        rq[$];
    logic [31:0] nq[$];

    localparam logic [255:0] IV   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [639:0] BASE = {16{40'h123456789A}};

    // Mock core compression: rotate the state and fold in both message halves.
    function automatic logic [255:0] step(input logic [255:0] h, input logic [511:0] m);
        return {h[254:0], h[255]} ^ m[511:256] ^ m[255:0];
    endfunction

    function automatic logic [639:0] mk_hdr(input logic [31:0] n);
        logic [639:0] h;
        h = BASE;
        h[31:0] = n;
        return h;
    endfunction

    function automatic logic [255:0] exp_digest(input logic [639:0] hdr, input logic [31:0] n);
        logic [511:0] b1;
        logic [511:0] b2;
        logic [255:0] h;
        b1 = hdr[639:128];
        b2 = {hdr[127:32], n, 1'b1, 319'b0, 64'd640};
        h  = step(step(IV, b1), b2);
`ifdef DOUBLE_HASH_EN
        h  = step(IV, {h, 1'b1, 191'b0, 64'd256});
`endif
        return h;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mock SHA core: 4 cycles per block, digest presented with a one-cycle done pulse.
    int           m_blocks = 0;
    int           m_cnt    = 0;
    int           m_idx    = 0;
    logic [1:0]   m_type   = 2'd0;
    logic [255:0] m_h      = '0;
    logic [255:0] last_h1  = '0;
    logic         prev_start = 1'b0;

    always @(negedge CLK) begin
        m_done = 1'b0;
        if (!nreset) begin
            m_blocks   = 0;
            prev_start = 1'b0;
        end else begin
            if (prev_start) chk("start_not_back_to_back", core_start, 0);
            prev_start = core_start;
            if (core_start) begin
                m_type   = core_blk_type;
                m_blocks = (core_blk_type == 2'd2) ? 2 : 1;
                m_cnt    = 3;
                m_idx    = 0;
                m_h      = IV;
            end else if (m_blocks != 0) begin
                if (m_cnt != 0) begin
                    m_cnt--;
                end else begin
                    if (m_type == 2'd2 && m_idx == 1) begin
                        if (nq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL blk2_nonce: got unexpected block with nonce %0h expected none", core_msg[415:384]);
                        end else begin
                            chk("blk2_nonce", core_msg[415:384], nq.pop_front());
                        end
                        chk("blk2_pad_bit", core_msg[383], 1);
                        chk("blk2_len", core_msg[63:0], 64'h280);
                    end
                    if (m_type == 2'd0) begin
                        chk("h2_pad_bit", core_msg[255], 1);
                        chk("h2_len", core_msg[63:0], 64'h100);
                        chk("h2_first_digest", core_msg[511:256], last_h1);
                    end
                    m_h = step(m_h, core_msg);
                    if (m_type == 2'd2 && m_idx == 1) last_h1 = m_h;
                    core_hash = m_h;
                    m_done    = 1'b1;
                    m_idx++;
                    m_blocks--;
                    m_cnt = 3;
                end
            end
        end
    end

    // Result monitor: pops an expectation on every done pulse.
    logic prev_done = 1'b0;
    res_t mon_e;

    always @(negedge CLK) begin
        if (prev_done) chk("done_one_cycle", done, 0);
        prev_done = done;
        if (done) begin
            done_cnt++;
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done pulse with nonce_out %0h expected none", nonce_out);
            end else begin
                mon_e = rq.pop_front();
                chk("found", found, mon_e.fnd);
                chk("nonce_out", nonce_out, mon_e.nonce);
                chk("digest", digest, mon_e.dig);
            end
        end
    end

    task automatic expect_run(input logic [639:0] hdr, input int ntries,
                              input logic exp_found, input logic [31:0] exp_nonce);
        res_t r;
        logic [31:0] n;
        n = hdr[31:0];
        for (int i = 0; i < ntries; i++) begin
            nq.push_back(n);
            n = n + 32'd1;
        end
        r.fnd   = exp_found;
        r.nonce = exp_nonce;
        r.dig   = exp_digest(hdr, exp_nonce);
        rq.push_back(r);
    endtask

    task automatic search(input logic [639:0] hdr, input logic [255:0] tgt, input logic [31:0] cnt);
        @(negedge CLK);
        header      = hdr;
        target      = tgt;
        nonce_count = cnt;
        go          = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        chk("busy_after_go", busy, 1);
        chk("found_cleared_by_go", found, 0);
    endtask

    task automatic wait_done();
        int s;
        s = done_cnt;
        for (int k = 0; k < 3000 && done_cnt == s; k++) @(negedge CLK);
        checks++;
        if (done_cnt == s) begin
            errors++;
            $display("FAIL done_timeout: got no done within 3000 cycles expected a done pulse");
        end
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] d;
        logic         hit;
        int           s;

        go = 1'b0;
        header = '0;
        target = '0;
        nonce_count = '0;
        nreset = 1'b1;
        #1 nreset = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_blk_type", core_blk_type, 0);
        chk("rst_core_msg", core_msg, 0);
        chk("rst_nonce_out", nonce_out, 0);
        chk("rst_digest", digest, 0);
        #2 nreset = 1'b1;

        // Everything passes: single iteration at the start nonce.
        expect_run(mk_hdr(32'h5), 1, 1'b1, 32'h5);
        search(mk_hdr(32'h5), {256{1'b1}}, 32'd4);
        wait_done();

        // Nothing passes: three tries, last nonce reported.
        expect_run(mk_hdr(32'h10), 3, 1'b0, 32'h12);
        search(mk_hdr(32'h10), '0, 32'd3);
        wait_done();

        // Nonce wraps from all-ones to zero.
        expect_run(mk_hdr(32'hFFFFFFFF), 2, 1'b0, 32'h0);
        search(mk_hdr(32'hFFFFFFFF), '0, 32'd2);
        wait_done();

        // nonce_count of zero still makes one try.
        expect_run(mk_hdr(32'h7), 1, 1'b0, 32'h7);
        search(mk_hdr(32'h7), '0, 32'd0);
        wait_done();

        // Boundary: digest equal to target passes, target one below fails.
        d = exp_digest(mk_hdr(32'h30), 32'h30);
        expect_run(mk_hdr(32'h30), 1, 1'b1, 32'h30);
        search(mk_hdr(32'h30), d, 32'd2);
        wait_done();
        expect_run(mk_hdr(32'h30), 1, 1'b0, 32'h30);
        search(mk_hdr(32'h30), d - 256'd1, 32'd1);
        wait_done();

        // A go while busy must not restart the search.
        expect_run(mk_hdr(32'h20), 1, 1'b1, 32'h20);
        search(mk_hdr(32'h20), {256{1'b1}}, 32'd1);
        repeat (4) @(negedge CLK);
        header = mk_hdr(32'h99);
        go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        wait_done();

        // Stray core_blk_done while idle is ignored.
        s = done_cnt;
        inj_done = 1'b1;
        @(negedge CLK);
        inj_done = 1'b0;
        chk("stray_done_busy", busy, 0);
        repeat (5) @(negedge CLK);
        chk("stray_done_no_pulse", done_cnt, s);

        // Reset in the last block of a search abandons it without done.
        nq.push_back(32'h40);
        search(mk_hdr(32'h40), '0, 32'd5);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge CLK);
            #1;
`ifdef DOUBLE_HASH_EN
            hit = (m_type == 2'd0 && m_blocks != 0 && m_cnt < 3);
`else
            hit = (m_type == 2'd2 && m_idx == 1 && m_blocks != 0 && m_cnt < 3);
`endif
        end
        chk("reached_last_block", hit, 1);
        s = done_cnt;
        #1 nreset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_core_start", core_start, 0);
        chk("abort_nonce_out", nonce_out, 0);
        repeat (3) @(negedge CLK);
        #2 nreset = 1'b1;
        nq.delete();
        repeat (20) @(negedge CLK);
        chk("abort_no_done", done_cnt, s);

        // Fresh go restarts from header[31:0].
        expect_run(mk_hdr(32'h40), 1, 1'b1, 32'h40);
        search(mk_hdr(32'h40), {256{1'b1}}, 32'd1);
        wait_done();

        repeat (5) @(negedge CLK);
        chk("results_drained", rq.size(), 0);
        chk("blocks_drained", nq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
